// File: rtl/complete_queue_if.sv
// Complete bus: up to WIDTH finished results per cycle, lane 0 oldest.
// The queue drives it; RS wakeup, ROB and map-table ready logic listen.
interface complete_queue_if #(
   parameter int WIDTH = 3,
   parameter int PHY_W = 6,
   parameter int ROB_W = 5,
   parameter int EXC_W = 4
);
   logic [WIDTH-1:0]            valid;
   logic [WIDTH-1:0][PHY_W-1:0] dst;
   logic [WIDTH-1:0][ROB_W-1:0] rob_idx;
   logic [WIDTH-1:0]            exc_valid;
   logic [WIDTH-1:0][EXC_W-1:0] exc;

   modport master (output valid, dst, rob_idx, exc_valid, exc);
   modport cq     (output valid, dst, rob_idx, exc_valid, exc);
   modport slave  (input  valid, dst, rob_idx, exc_valid, exc);
endinterface

// File: rtl/complete_queue.sv
// Completion queue: packs FU results into a circular buffer and drains up to
// WIDTH of them per cycle onto the complete bus, oldest first.
module complete_queue #(
   parameter int N_FU  = 4,
   parameter int DEPTH = 8,
   parameter int WIDTH = 3,
   parameter int PHY_W = 6,
   parameter int ROB_W = 5,
   parameter int EXC_W = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_flush,
   input  logic [N_FU-1:0]             i_fu_valid,
   input  logic [N_FU-1:0][PHY_W-1:0]  i_fu_dst,
   input  logic [N_FU-1:0][ROB_W-1:0]  i_fu_rob_idx,
   input  logic [N_FU-1:0]             i_fu_exc_valid,
   input  logic [N_FU-1:0][EXC_W-1:0]  i_fu_exc,
   output logic                        o_fu_ready,
   complete_queue_if.cq                cmp
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IN_W  = $clog2(N_FU + 1);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_fu_ready;

   logic [PHY_W-1:0] r_dst       [DEPTH];
   logic [ROB_W-1:0] r_rob_idx   [DEPTH];
   logic             r_exc_valid [DEPTH];
   logic [EXC_W-1:0] r_exc       [DEPTH];

   logic [N_FU-1:0]  w_accept;
   logic [IN_W-1:0]  w_n_in;
   logic [PTR_W-1:0] w_slot   [N_FU];
   logic [CNT_W-1:0] w_n_out;
   logic [CNT_W-1:0] w_count_next;
   logic [PTR_W-1:0] w_rd_idx [WIDTH];

   assign w_accept   = i_fu_valid & {N_FU{r_fu_ready & ~i_flush}};
   assign o_fu_ready = r_fu_ready;

   // Pack accepted lanes densely from tail in ascending lane order.
   always_comb begin
      w_n_in = '0;
      for (int i = 0; i < N_FU; i++) begin
         w_slot[i] = r_tail + PTR_W'(w_n_in);
         if (w_accept[i]) begin
            w_n_in = w_n_in + IN_W'(1);
         end else begin
            w_n_in = w_n_in;
         end
      end
   end

   // Drain the oldest min(count, WIDTH) entries; idle lanes are forced to zero.
   always_comb begin
      w_n_out       = (r_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : r_count;
      w_count_next  = r_count + CNT_W'(w_n_in) - w_n_out;
      cmp.valid     = '0;
      cmp.dst       = '0;
      cmp.rob_idx   = '0;
      cmp.exc_valid = '0;
      cmp.exc       = '0;
      for (int k = 0; k < WIDTH; k++) begin
         w_rd_idx[k] = r_head + PTR_W'(k);
         if (CNT_W'(k) < w_n_out) begin
            cmp.valid[k]     = 1'b1;
            cmp.dst[k]       = r_dst[w_rd_idx[k]];
            cmp.rob_idx[k]   = r_rob_idx[w_rd_idx[k]];
            cmp.exc_valid[k] = r_exc_valid[w_rd_idx[k]];
            cmp.exc[k]       = r_exc[w_rd_idx[k]];
         end else begin
            cmp.valid[k]     = 1'b0;
         end
      end
   end

   // Pointers, occupancy and the ready grant; ready is precomputed from the next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fu_ready <= 1'b1;
      end else if (i_flush) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fu_ready <= 1'b1;
      end else begin
         r_head     <= r_head + PTR_W'(w_n_out);
         r_tail     <= r_tail + PTR_W'(w_n_in);
         r_count    <= w_count_next;
         r_fu_ready <= (CNT_W'(DEPTH) - w_count_next) >= CNT_W'(N_FU);
      end
   end

   // Payload storage; entries carry no reset since valid comes from count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_FU; i++) begin
         if (w_accept[i]) begin
            r_dst[w_slot[i]]       <= i_fu_dst[i];
            r_rob_idx[w_slot[i]]   <= i_fu_rob_idx[i];
            r_exc_valid[w_slot[i]] <= i_fu_exc_valid[i];
            r_exc[w_slot[i]]       <= i_fu_exc[i];
         end
      end
   end

   complete_queue_chk #(
      .N_FU  (N_FU),
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_count    (r_count),
      .i_fu_ready (r_fu_ready),
      .i_accept   (w_accept),
      .i_valid    (cmp.valid)
   );
endmodule

// Structural invariants of the queue, observed from its internal state.
module complete_queue_chk #(
   parameter int N_FU  = 4,
   parameter int DEPTH = 8,
   parameter int WIDTH = 3
) (
   input logic                         clk,
   input logic                         rst_n,
   input logic [$clog2(DEPTH+1)-1:0]   i_count,
   input logic                         i_fu_ready,
   input logic [N_FU-1:0]              i_accept,
   input logic [WIDTH-1:0]             i_valid
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      i_count <= CNT_W'(DEPTH));

   a_no_enq_when_full : assert property (@(posedge clk) disable iff (!rst_n)
      !i_fu_ready |-> (i_accept == '0));

   a_valid_contiguous : assert property (@(posedge clk) disable iff (!rst_n)
      (i_valid & (i_valid + WIDTH'(1))) == '0);
endmodule

// File: tb/tb_complete_queue.sv
// Directed and random stimulus for complete_queue, checked against a
// queue-of-entries reference model built from the FIFO/grant rules.
module tb_complete_queue;
   localparam int N_FU  = 4;
   localparam int DEPTH = 8;
   localparam int WIDTH = 3;
   localparam int PHY_W = 6;
   localparam int ROB_W = 5;
   localparam int EXC_W = 4;

   typedef struct packed {
      logic [PHY_W-1:0] dst;
      logic [ROB_W-1:0] rob;
      logic             ev;
      logic [EXC_W-1:0] exc;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic [N_FU-1:0]            fu_valid;
   logic [N_FU-1:0][PHY_W-1:0] fu_dst;
   logic [N_FU-1:0][ROB_W-1:0] fu_rob;
   logic [N_FU-1:0]            fu_ev;
   logic [N_FU-1:0][EXC_W-1:0] fu_exc;
   logic                       fu_ready;

   int   n_asserts = 0;
   int   n_fail    = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   complete_queue_if #(.WIDTH(WIDTH), .PHY_W(PHY_W), .ROB_W(ROB_W), .EXC_W(EXC_W)) cmp_if ();

   complete_queue #(
      .N_FU(N_FU), .DEPTH(DEPTH), .WIDTH(WIDTH),
      .PHY_W(PHY_W), .ROB_W(ROB_W), .EXC_W(EXC_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_flush        (flush),
      .i_fu_valid     (fu_valid),
      .i_fu_dst       (fu_dst),
      .i_fu_rob_idx   (fu_rob),
      .i_fu_exc_valid (fu_ev),
      .i_fu_exc       (fu_exc),
      .o_fu_ready     (fu_ready),
      .cmp            (cmp_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      flush    = 1'b0;
      fu_valid = '0;
      fu_dst   = '0;
      fu_rob   = '0;
      fu_ev    = '0;
      fu_exc   = '0;
   endtask

   task automatic set_lane(input int i, input int d, input int r, input int ev, input int ex);
      fu_valid[i] = 1'b1;
      fu_dst[i]   = PHY_W'(d);
      fu_rob[i]   = ROB_W'(r);
      fu_ev[i]    = ev[0];
      fu_exc[i]   = EXC_W'(ex);
   endtask

   // One clock: compare bus and ready to the model, advance the model, cross the edge.
   task automatic step();
      int   n_exp;
      bit   mr;
      ent_t e;
      logic [WIDTH-1:0] exp_valid;
      #1;
      n_exp = (q.size() < WIDTH) ? q.size() : WIDTH;
      mr    = (DEPTH - q.size()) >= N_FU;
      exp_valid = '0;
      for (int k = 0; k < WIDTH; k++) exp_valid[k] = (k < n_exp);
      chk("valid", 32'(cmp_if.valid), 32'(exp_valid));
      chk("fu_ready", 32'(fu_ready), 32'(mr));
      for (int k = 0; k < WIDTH; k++) begin
         e = (k < n_exp) ? q[k] : '0;
         chk($sformatf("dst%0d", k),  32'(cmp_if.dst[k]),       32'(e.dst));
         chk($sformatf("rob%0d", k),  32'(cmp_if.rob_idx[k]),   32'(e.rob));
         chk($sformatf("ev%0d", k),   32'(cmp_if.exc_valid[k]), 32'(e.ev));
         chk($sformatf("exc%0d", k),  32'(cmp_if.exc[k]),       32'(e.exc));
      end
      if (flush) begin
         q.delete();
      end else begin
         repeat (n_exp) void'(q.pop_front());
         if (mr) begin
            for (int i = 0; i < N_FU; i++) begin
               if (fu_valid[i]) q.push_back('{dst: fu_dst[i], rob: fu_rob[i], ev: fu_ev[i], exc: fu_exc[i]});
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bit mr;
      rst_n = 1'b0;
      clear_in();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_valid", 32'(cmp_if.valid), 32'(3'b000));
      chk("rst_ready", 32'(fu_ready), 32'(1'b1));
      step();

      // single result on lane 2
      set_lane(2, 17, 5, 0, 0);
      step();
      clear_in();
      chk("t2_valid", 32'(cmp_if.valid), 32'(3'b001));
      chk("t2_dst", 32'(cmp_if.dst[0]), 32'd17);
      chk("t2_rob", 32'(cmp_if.rob_idx[0]), 32'd5);
      step();
      chk("t2_valid_e2", 32'(cmp_if.valid), 32'(3'b000));

      // two back-to-back bursts of four
      for (int i = 0; i < 4; i++) set_lane(i, i + 1, i + 1, 0, 0);
      step();
      for (int i = 0; i < 4; i++) set_lane(i, i + 5, i + 5, 0, 0);
      step();
      clear_in();
      chk("t3_valid_b", 32'(cmp_if.valid), 32'(3'b111));
      chk("t3_dst_b0", 32'(cmp_if.dst[0]), 32'd4);
      chk("t3_dst_b2", 32'(cmp_if.dst[2]), 32'd6);
      chk("t3_ready", 32'(fu_ready), 32'(1'b0));
      step();
      chk("t3_valid_c", 32'(cmp_if.valid), 32'(3'b011));
      chk("t3_dst_c1", 32'(cmp_if.dst[1]), 32'd8);
      step();

      // sparse lanes pack without holes
      set_lane(1, 9, 3, 1, 7);
      set_lane(3, 33, 4, 0, 0);
      step();
      clear_in();
      chk("t4_valid", 32'(cmp_if.valid), 32'(3'b011));
      chk("t4_dst0", 32'(cmp_if.dst[0]), 32'd9);
      chk("t4_dst1", 32'(cmp_if.dst[1]), 32'd33);
      chk("t4_exc0", 32'(cmp_if.exc[0]), 32'd7);
      step();

      // flush with a nearly full queue and all lanes presenting
      for (int i = 0; i < 4; i++) set_lane(i, 20 + i, i, 0, 0);
      step();
      for (int i = 0; i < 4; i++) set_lane(i, 30 + i, 8 + i, 0, 0);
      step();
      flush = 1'b1;
      for (int i = 0; i < 4; i++) set_lane(i, 40 + i, 16 + i, 0, 0);
      chk("t5_valid_flush", 32'(cmp_if.valid), 32'(3'b111));
      step();
      clear_in();
      chk("t5_valid_after", 32'(cmp_if.valid), 32'(3'b000));
      chk("t5_ready_after", 32'(fu_ready), 32'(1'b1));
      step();

      // asynchronous reset in the middle of a busy cycle
      for (int i = 0; i < 4; i++) set_lane(i, 50 + i, i, 0, 0);
      step();
      for (int i = 0; i < 4; i++) set_lane(i, 54 + i, 4 + i, 0, 0);
      step();
      clear_in();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_valid", 32'(cmp_if.valid), 32'(3'b000));
      chk("t1_ready", 32'(fu_ready), 32'(1'b1));
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // random traffic; FUs hold their lanes while the grant is low
      for (int c = 0; c < 40; c++) begin
         mr = (DEPTH - q.size()) >= N_FU;
         if (mr || flush) begin
            clear_in();
            for (int i = 0; i < N_FU; i++) begin
               if ($urandom_range(0, 1) == 1) begin
                  set_lane(i, $urandom_range(0, 63), $urandom_range(0, 31),
                           $urandom_range(0, 1), $urandom_range(0, 15));
               end
            end
            flush = ($urandom_range(0, 15) == 0);
         end
         step();
      end
      clear_in();
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
